// File: rtl/soc_system_pio_out_pulse.sv
// Avalon-MM output PIO with set/clear/toggle writes and a one-shot pulse engine.
// out_port = data_reg ^ pulse_mask. A PULSE write inverts the selected bits for
// max(len_reg,1) cycles, after which the mask clears and the pins restore.

module soc_system_pio_out_pulse #(
  parameter int unsigned       WIDTH       = 8,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
  parameter int unsigned       CNT_W       = 16,
  parameter logic [CNT_W-1:0]  DEFAULT_LEN = CNT_W'(1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             pulse_busy
);

  localparam logic [2:0] AddrData   = 3'd0;
  localparam logic [2:0] AddrLen    = 3'd1;
  localparam logic [2:0] AddrPulse  = 3'd2;
  localparam logic [2:0] AddrStatus = 3'd3;
  localparam logic [2:0] AddrSet    = 3'd4;
  localparam logic [2:0] AddrClear  = 3'd5;
  localparam logic [2:0] AddrToggle = 3'd6;

  typedef enum logic {StIdle, StActive} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] pulse_mask_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] cnt_q;
  logic             overrun_q;

  logic             wr_strobe;
  logic             wr_pulse;
  logic             wr_status;
  logic [WIDTH-1:0] wd_bits;
  logic [CNT_W-1:0] wd_len;
  logic [CNT_W-1:0] len_start;
  logic             unused_writedata;

  assign wr_strobe = chipselect & ~write_n;
  assign wr_pulse  = wr_strobe && (address == AddrPulse);
  assign wr_status = wr_strobe && (address == AddrStatus);
  assign wd_bits   = writedata[WIDTH-1:0];
  assign wd_len    = writedata[CNT_W-1:0];

  // Bits above WIDTH/CNT_W are deliberately ignored.
  assign unused_writedata = ^writedata;

  // A programmed length of zero is treated as a one-cycle pulse.
  assign len_start = (len_q == '0) ? '0 : len_q - CNT_W'(1);

  // Data and length registers: direct, set, clear and toggle writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RESET_VALUE;
      len_q  <= DEFAULT_LEN;
    end else if (wr_strobe) begin
      case (address)
        AddrData:   data_q <= wd_bits;
        AddrLen:    len_q  <= wd_len;
        AddrSet:    data_q <= data_q | wd_bits;
        AddrClear:  data_q <= data_q & ~wd_bits;
        AddrToggle: data_q <= data_q ^ wd_bits;
        default:    ;
      endcase
    end
  end

  // Pulse engine FSM with overrun flag; an overrun set beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      pulse_mask_q <= '0;
      cnt_q        <= '0;
      overrun_q    <= 1'b0;
    end else begin
      if (wr_status && writedata[1]) begin
        overrun_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (wr_pulse && (wd_bits != '0)) begin
            pulse_mask_q <= wd_bits;
            cnt_q        <= len_start;
            state_q      <= StActive;
          end
        end
        StActive: begin
          // Length was latched at start; a new request here is dropped and flagged.
          if (wr_pulse) begin
            overrun_q <= 1'b1;
          end
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            pulse_mask_q <= '0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_port   = data_q ^ pulse_mask_q;
  assign pulse_busy = (state_q == StActive);

  // Combinational, side-effect-free read mux; unused upper bits read as zero.
  always_comb begin
    readdata = '0;
    case (address)
      AddrData:   readdata[WIDTH-1:0] = data_q;
      AddrLen:    readdata[CNT_W-1:0] = len_q;
      AddrPulse:  readdata[WIDTH-1:0] = pulse_mask_q;
      AddrStatus: readdata[1:0]       = {overrun_q, pulse_busy};
      default:    ;
    endcase
  end

endmodule

// File: tb/tb_soc_system_pio_out_pulse.sv
// Self-checking bench for soc_system_pio_out_pulse (WIDTH=8, CNT_W=16).
// Reference model tracks pulse timing as "cycles of inversion still owed".

module tb_soc_system_pio_out_pulse;

  localparam int W  = 8;
  localparam int CW = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [W-1:0] out_port;
  logic        pulse_busy;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [W-1:0]  m_data;
  logic [W-1:0]  m_mask;
  logic [CW-1:0] m_len;
  int            m_remain;
  bit            m_ovr;

  soc_system_pio_out_pulse #(
    .WIDTH       (W),
    .RESET_VALUE (8'h00),
    .CNT_W       (CW),
    .DEFAULT_LEN (16'd1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .pulse_busy (pulse_busy)
  );

  always #5 clk = ~clk;

  function automatic void m_reset();
    m_data   = 8'h00;
    m_len    = 16'd1;
    m_mask   = '0;
    m_remain = 0;
    m_ovr    = 1'b0;
  endfunction

  // Effect of one clock edge given the bus transaction presented before it.
  function automatic void m_edge(bit wr, logic [2:0] a, logic [31:0] d);
    bit was_busy;
    logic [W-1:0] dm;
    was_busy = (m_remain > 0);
    dm = d[W-1:0];
    if (was_busy) begin
      m_remain = m_remain - 1;
      if (m_remain == 0) m_mask = '0;
    end
    if (wr) begin
      case (a)
        3'd0: m_data = dm;
        3'd1: m_len = d[CW-1:0];
        3'd2: begin
          if (was_busy) m_ovr = 1'b1;
          else if (dm != '0) begin
            m_mask   = dm;
            m_remain = (m_len == 0) ? 1 : int'(m_len);
          end
        end
        3'd3: if (d[1]) m_ovr = 1'b0;
        3'd4: m_data = m_data | dm;
        3'd5: m_data = m_data & ~dm;
        3'd6: m_data = m_data ^ dm;
        default: ;
      endcase
    end
  endfunction

  function automatic logic [31:0] m_read(logic [2:0] a);
    case (a)
      3'd0:    return {24'd0, m_data};
      3'd1:    return {16'd0, m_len};
      3'd2:    return {24'd0, m_mask};
      3'd3:    return {30'd0, m_ovr, (m_remain > 0)};
      default: return 32'd0;
    endcase
  endfunction

  // One bus cycle: inputs applied at posedge+1, returns at next posedge+1.
  task automatic cycle(input bit cs, input bit wr, input logic [2:0] a, input logic [31:0] d);
    chipselect = cs;
    write_n    = !wr;
    address    = a;
    writedata  = d;
    @(posedge clk);
    m_edge(cs && wr, a, d);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = $urandom;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, address, $urandom);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (out_port !== 8'h00) begin
      bad++; $display("FAIL reset out_port: got %h want 00", out_port);
    end
    total++;
    if (pulse_busy !== 1'b0) begin
      bad++; $display("FAIL reset busy: got %b want 0", pulse_busy);
    end
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1;
      total++;
      if (readdata !== m_read(3'(a))) begin
        bad++; $display("FAIL reset read[%0d]: got %h want %h", a, readdata, m_read(3'(a)));
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reg_ops();
    logic [W-1:0] want [4];
    logic [2:0]   adr  [4];
    logic [31:0]  dat  [4];
    adr = '{3'd0, 3'd4, 3'd5, 3'd6};
    dat = '{32'h0000_00A5, 32'hFFFF_FF0F, 32'h0000_0081, 32'h1234_56FF};
    want = '{8'hA5, 8'hAF, 8'h2E, 8'hD1};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, adr[i], dat[i]);
      total++;
      if (out_port !== want[i]) begin
        bad++; $display("FAIL reg_ops step%0d out_port: got %h want %h", i, out_port, want[i]);
      end
    end
    address = 3'd4;
    #1;
    total++;
    if (readdata !== 32'd0) begin
      bad++; $display("FAIL reg_ops read4: got %h want 0", readdata);
    end
    address = 3'd0;
    #1;
    total++;
    if (readdata !== 32'h0000_00D1) begin
      bad++; $display("FAIL reg_ops readDATA: got %h want 000000d1", readdata);
    end
    for (int i = 0; i < 20; i++) begin
      logic [2:0] a;
      a = (i % 4 == 0) ? 3'd0 : 3'(3 + (i % 4));
      cycle(1'b1, 1'b1, a, $urandom);
      total++;
      if (out_port !== (m_data ^ m_mask)) begin
        bad++; $display("FAIL reg_ops rand%0d out_port: got %h want %h", i, out_port, m_data);
      end
    end
  endtask

  task automatic test_pulse_basic();
    int hi_cnt;
    int busy_cnt;
    hi_cnt = 0;
    busy_cnt = 0;
    cycle(1'b1, 1'b1, 3'd1, 32'd3);
    cycle(1'b1, 1'b1, 3'd0, 32'd0);
    cycle(1'b1, 1'b1, 3'd2, 32'hFFFF_FF01);
    for (int i = 0; i < 6; i++) begin
      total++;
      if (out_port !== (m_data ^ m_mask) || pulse_busy !== (m_remain > 0)) begin
        bad++; $display("FAIL pulse_basic c%0d: got out=%h busy=%b want out=%h busy=%b",
                        i + 1, out_port, pulse_busy, m_data ^ m_mask, m_remain > 0);
      end
      if (out_port === 8'h01) hi_cnt++;
      if (pulse_busy === 1'b1) busy_cnt++;
      idle();
    end
    total++;
    if (hi_cnt != 3 || busy_cnt != 3) begin
      bad++; $display("FAIL pulse_basic length: got hi=%0d busy=%0d want 3 3", hi_cnt, busy_cnt);
    end
  endtask

  task automatic test_len_zero_overrun();
    cycle(1'b1, 1'b1, 3'd1, 32'hABCD_0000);
    cycle(1'b1, 1'b1, 3'd2, 32'd2);
    total++;
    if (out_port !== 8'h02 || pulse_busy !== 1'b1) begin
      bad++; $display("FAIL len0 c1: got out=%h busy=%b want 02 1", out_port, pulse_busy);
    end
    idle();
    total++;
    if (out_port !== 8'h00 || pulse_busy !== 1'b0) begin
      bad++; $display("FAIL len0 c2: got out=%h busy=%b want 00 0", out_port, pulse_busy);
    end
    // Long pulse with a second request at cycle 4
    cycle(1'b1, 1'b1, 3'd1, 32'd10);
    cycle(1'b1, 1'b1, 3'd2, 32'd1);
    repeat (3) idle();
    cycle(1'b1, 1'b1, 3'd2, 32'd4);
    address = 3'd3;
    #1;
    total++;
    if (readdata !== 32'd3 || out_port !== 8'h01) begin
      bad++; $display("FAIL overrun during: got status=%h out=%h want 3 01", readdata, out_port);
    end
    for (int i = 0; i < 8; i++) begin
      idle();
      total++;
      if (out_port !== (m_data ^ m_mask) || pulse_busy !== (m_remain > 0)) begin
        bad++; $display("FAIL overrun tail%0d: got out=%h busy=%b want out=%h busy=%b",
                        i, out_port, pulse_busy, m_data ^ m_mask, m_remain > 0);
      end
    end
    address = 3'd3;
    #1;
    total++;
    if (readdata !== 32'd2) begin
      bad++; $display("FAIL overrun after: got status=%h want 2", readdata);
    end
    cycle(1'b1, 1'b1, 3'd3, 32'd2);
    #1;
    total++;
    if (readdata !== 32'd0) begin
      bad++; $display("FAIL overrun clear: got status=%h want 0", readdata);
    end
    // Request on the final active cycle still counts as overrun
    cycle(1'b1, 1'b1, 3'd1, 32'd2);
    cycle(1'b1, 1'b1, 3'd2, 32'd1);
    idle();
    cycle(1'b1, 1'b1, 3'd2, 32'd8);
    address = 3'd3;
    #1;
    total++;
    if (readdata !== 32'd2 || out_port !== 8'h00) begin
      bad++; $display("FAIL overrun final: got status=%h out=%h want 2 00", readdata, out_port);
    end
    cycle(1'b1, 1'b1, 3'd3, 32'd1);
    #1;
    total++;
    if (readdata !== 32'd2) begin
      bad++; $display("FAIL overrun bit0 write: got status=%h want 2", readdata);
    end
    cycle(1'b1, 1'b1, 3'd3, 32'hFFFF_FFFE);
    #1;
    total++;
    if (readdata !== 32'd0) begin
      bad++; $display("FAIL overrun clear2: got status=%h want 0", readdata);
    end
  endtask

  task automatic test_write_during_pulse();
    cycle(1'b1, 1'b1, 3'd0, 32'd0);
    cycle(1'b1, 1'b1, 3'd1, 32'd5);
    cycle(1'b1, 1'b1, 3'd2, 32'd1);
    total++;
    if (out_port !== 8'h01) begin
      bad++; $display("FAIL wdp c1: got out=%h want 01", out_port);
    end
    idle();
    cycle(1'b1, 1'b1, 3'd4, 32'd1);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (out_port !== 8'h00 || pulse_busy !== 1'b1) begin
        bad++; $display("FAIL wdp c%0d: got out=%h busy=%b want 00 1", i + 3, out_port, pulse_busy);
      end
      idle();
    end
    total++;
    if (out_port !== 8'h01 || pulse_busy !== 1'b0) begin
      bad++; $display("FAIL wdp end: got out=%h busy=%b want 01 0", out_port, pulse_busy);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [2:0]  a;
      logic [31:0] d;
      bit          cs;
      bit          wr;
      a  = 3'($urandom_range(0, 7));
      d  = $urandom;
      if (a == 3'd1) d = {d[31:16], 16'($urandom_range(0, 6))};
      cs = ($urandom_range(0, 3) != 0);
      wr = ($urandom_range(0, 2) != 0);
      cycle(cs, wr, a, d);
      total++;
      if (out_port !== (m_data ^ m_mask) || pulse_busy !== (m_remain > 0)) begin
        bad++; $display("FAIL random%0d out: got out=%h busy=%b want out=%h busy=%b",
                        i, out_port, pulse_busy, m_data ^ m_mask, m_remain > 0);
      end
      total++;
      if (readdata !== m_read(a)) begin
        bad++; $display("FAIL random%0d read[%0d]: got %h want %h", i, a, readdata, m_read(a));
      end
    end
    repeat (10) idle();
  endtask

  task automatic test_reset_mid_pulse();
    cycle(1'b1, 1'b1, 3'd0, 32'h3C);
    cycle(1'b1, 1'b1, 3'd1, 32'd8);
    cycle(1'b1, 1'b1, 3'd2, 32'hFF);
    total++;
    if (out_port !== 8'hC3 || pulse_busy !== 1'b1) begin
      bad++; $display("FAIL rst_mid c1: got out=%h busy=%b want c3 1", out_port, pulse_busy);
    end
    idle();
    #1;
    reset_n = 1'b0;
    m_reset();
    #1;
    total++;
    if (out_port !== 8'h00 || pulse_busy !== 1'b0) begin
      bad++; $display("FAIL rst_mid async: got out=%h busy=%b want 00 0", out_port, pulse_busy);
    end
    address = 3'd2;
    #1;
    total++;
    if (readdata !== 32'd0) begin
      bad++; $display("FAIL rst_mid mask: got %h want 0", readdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    address = 3'd1;
    #1;
    total++;
    if (readdata !== 32'd1 || out_port !== 8'h00) begin
      bad++; $display("FAIL rst_mid after: got len=%h out=%h want 1 00", readdata, out_port);
    end
  endtask

  initial begin
    test_reset();
    test_reg_ops();
    test_pulse_basic();
    test_len_zero_overrun();
    test_write_during_pulse();
    test_random();
    test_reset_mid_pulse();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
